mcp9808_scheduler: RTL

MCP9808_SCHEDULER -- requirements
Module: mcp9808_scheduler

---
 rtl/mcp9808_pkg.sv | 30 +++
 rtl/mcp9808_poll_timer.sv | 32 +++
 rtl/mcp9808_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mcp9808_pkg.sv
// Shared types and constants for the MCP9808 read/write scheduler.
package mcp9808_pkg;

    localparam int unsigned TEMP_W  = 12;
    localparam int unsigned WTEMP_W = 11;
    localparam int unsigned COMP_W  = 3;
    localparam int unsigned SEL_W   = 2;

    localparam logic [SEL_W-1:0] SEL_NONE  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_UPPER = 2'b01;
    localparam logic [SEL_W-1:0] SEL_LOWER = 2'b10;
    localparam logic [SEL_W-1:0] SEL_CRIT  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_HOLD,
        WR_WAIT
    } schedState_t;

    // One captured reading from the sensor interface.
    typedef struct packed {
        logic              sign;
        logic [TEMP_W-1:0] temp;
        logic [COMP_W-1:0] comp;
    } sample_t;

endpackage

// File: rtl/mcp9808_poll_timer.sv
// Free-running poll timer: one-cycle tick every POLL_PERIOD cycles while enabled.
module mcp9808_poll_timer #(
    parameter int unsigned POLL_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [CNT_W-1:0] count;

    // Count while enabled, hold at reload otherwise; tick on terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CNT_W'(POLL_PERIOD - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/mcp9808_scheduler.sv
// MCP9808 scheduler: arbitrates periodic/immediate reads and limit writes
// onto a single sensor interface. Optional watchdog: MCP9808_SCHED_WDT_EN.
module mcp9808_scheduler
    import mcp9808_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 10000000,
    parameter int unsigned WDT_CYCLES  = 2000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               poll_now,
    input  logic               wr_req,
    input  logic [SEL_W-1:0]   wr_sel,
    input  logic [WTEMP_W-1:0] wr_temp,
    input  logic               if_ready,
    input  logic [TEMP_W-1:0]  if_temp,
    input  logic               if_sign,
    input  logic [COMP_W-1:0]  if_comp,
    output logic               if_update,
    output logic [SEL_W-1:0]   if_wsel,
    output logic [WTEMP_W-1:0] if_wtemp,
    output logic [TEMP_W-1:0]  temp_out,
    output logic               sign_out,
    output logic [COMP_W-1:0]  comp_out,
    output logic               valid,
    output logic               sample_stb,
    output logic               wr_ack,
    output logic               wr_done,
    output logic               busy,
    output logic               err
);

    schedState_t        state, stateNext;
    logic               tick;
    logic               rdPend, rdPendNext, rdClr;
    logic               wrPend, wrPendNext, wrClr, wrAccept;
    logic               capture, doneNext;
    logic               seenLow, seenLowNext;
    logic               wrActiveNext;
    logic [SEL_W-1:0]   selLatch;
    logic [WTEMP_W-1:0] wtempLatch;
    sample_t            sampleQ;

    mcp9808_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) uPollTimer (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign wrAccept     = wr_req && (wr_sel != SEL_NONE) && !wrPend;
    assign wrActiveNext = (stateNext == WR_ISSUE) || (stateNext == WR_HOLD);

`ifdef MCP9808_SCHED_WDT_EN
    localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

    logic [WDT_W-1:0] wdtCnt;
    logic             wdtActive, wdtExpire, errNext;

    assign wdtActive = (state == RD_WAIT) || (state == WR_HOLD) || (state == WR_WAIT);
    assign wdtExpire = wdtActive && (wdtCnt == WDT_W'(WDT_CYCLES - 1));
`endif

    // Next-state, request bookkeeping and output pulse decode.
    always_comb begin
        stateNext   = state;
        rdClr       = 1'b0;
        wrClr       = 1'b0;
        capture     = 1'b0;
        doneNext    = 1'b0;
        seenLowNext = seenLow;
`ifdef MCP9808_SCHED_WDT_EN
        errNext     = 1'b0;
`endif
        case (state)
            IDLE: begin
                seenLowNext = 1'b0;
                if (if_ready) begin
                    if (wrPend)      stateNext = WR_ISSUE;
                    else if (rdPend) stateNext = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                rdClr       = 1'b1;
                seenLowNext = 1'b0;
                stateNext   = RD_WAIT;
            end
            RD_WAIT: begin
                if (!if_ready) begin
                    seenLowNext = 1'b1;
                end else if (seenLow) begin
                    capture   = 1'b1;
                    stateNext = IDLE;
                end
            end
            WR_ISSUE: stateNext = WR_HOLD;
            WR_HOLD: begin
                if (!if_ready) stateNext = WR_WAIT;
            end
            WR_WAIT: begin
                if (if_ready) begin
                    doneNext  = 1'b1;
                    wrClr     = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
`ifdef MCP9808_SCHED_WDT_EN
        // Expiry only matters if the operation did not progress this cycle.
        if (wdtExpire && (stateNext == state)) begin
            errNext     = 1'b1;
            seenLowNext = 1'b0;
            stateNext   = IDLE;
            if (state == RD_WAIT) rdClr = 1'b1;
            else                  wrClr = 1'b1;
        end
`endif
        // New requests win over a same-cycle clear so they are never lost.
        rdPendNext = (rdPend && !rdClr) || tick || poll_now;
        wrPendNext = (wrPend && !wrClr) || wrAccept;
    end

    // State, pending flags, latched write and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rdPend     <= 1'b0;
            wrPend     <= 1'b0;
            seenLow    <= 1'b0;
            selLatch   <= SEL_NONE;
            wtempLatch <= '0;
            sampleQ    <= '0;
            valid      <= 1'b0;
            sample_stb <= 1'b0;
            wr_ack     <= 1'b0;
            wr_done    <= 1'b0;
            busy       <= 1'b0;
            if_update  <= 1'b0;
            if_wsel    <= SEL_NONE;
            if_wtemp   <= '0;
        end else begin
            state      <= stateNext;
            rdPend     <= rdPendNext;
            wrPend     <= wrPendNext;
            seenLow    <= seenLowNext;
            if (wrAccept) begin
                selLatch   <= wr_sel;
                wtempLatch <= wr_temp;
            end
            if (capture) begin
                sampleQ <= '{sign: if_sign, temp: if_temp, comp: if_comp};
                valid   <= 1'b1;
            end
            sample_stb <= capture;
            wr_ack     <= wrAccept;
            wr_done    <= doneNext;
            busy       <= (stateNext != IDLE) || rdPendNext || wrPendNext;
            if_update  <= (stateNext == RD_ISSUE);
            if_wsel    <= wrActiveNext ? selLatch : SEL_NONE;
            if_wtemp   <= wrActiveNext ? wtempLatch : '0;
        end
    end

    assign temp_out = sampleQ.temp;
    assign sign_out = sampleQ.sign;
    assign comp_out = sampleQ.comp;

`ifdef MCP9808_SCHED_WDT_EN
    // Watchdog: restarts on every state change, err pulses on expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdtCnt <= '0;
            err    <= 1'b0;
        end else begin
            wdtCnt <= (wdtActive && (stateNext == state)) ? wdtCnt + WDT_W'(1) : '0;
            err    <= errNext;
        end
    end
`else
    // No watchdog in this build: operations wait indefinitely.
    assign err = 1'b0;
    if (WDT_CYCLES == 0) begin : gWdtUnused
    end
`endif

endmodule
